// File: rtl/whackmole_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package whackmole_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPAWN  = 3'd1,
        ACTIVE = 3'd2,
        GAP    = 3'd3,
        OVER   = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [3:0]  MAX_LEVEL   = 4'd15;
    localparam int          BASE_WINDOW = 8;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/whackmole_if.sv
// Player-facing signal bundle of the whack-a-mole controller.
interface whackmole_if #(
    parameter int N_MOLES = 18,
    parameter int SCORE_W = 11
);
    logic               start;
    logic [N_MOLES-1:0] switch;
    logic [N_MOLES-1:0] moles;
    logic [SCORE_W-1:0] score;
    logic [2:0]         lives;
    logic [3:0]         level;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               game_over;

    modport master (
        output start, switch,
        input  moles, score, lives, level, hit_pulse, miss_pulse, game_over
    );

    modport slave (
        input  start, switch,
        output moles, score, lives, level, hit_pulse, miss_pulse, game_over
    );
endinterface

// File: rtl/whackmole_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick mole positions.
module lfsr16
    import whackmole_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= LFSR_SEED;
        end else begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/whackmole_game.sv
// Whack-a-mole game controller: tick divider, round FSM, scoring and lives.
// Mole positions come from lfsr16; every output is driven from a register.
module whackmole_game
    import whackmole_pkg::*;
#(
    parameter int N_MOLES    = 18,
    parameter int TICK_DIV   = 50_000_000,
    parameter int SCORE_W    = 11,
    parameter int LIVES      = 3,
    parameter int LEVEL_STEP = 8,
    parameter int MIN_WINDOW = 2
) (
    input  logic       clk,
    input  logic       reset,
    whackmole_if.slave bus
);
    // state  | meaning
    // IDLE   | after reset, waiting for start
    // SPAWN  | one cycle: pick and light a new mole, load the window
    // ACTIVE | mole lit, watching switch edges and the window
    // GAP    | dark interval, switches ignored until the next tick
    // OVER   | lives exhausted, final score held until start

    localparam int IDX_W = $clog2(N_MOLES);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HC_W  = $clog2(LEVEL_STEP + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [7:0]          r_window;
    logic [HC_W-1:0]     r_hitcnt;
    logic [IDX_W-1:0]    r_prev;
    logic [N_MOLES-1:0]  r_switch_q;
    logic [N_MOLES-1:0]  r_moles;
    logic [SCORE_W-1:0]  r_score;
    logic [2:0]          r_lives;
    logic [3:0]          r_level;
    logic                r_hit_pulse;
    logic                r_miss_pulse;
    logic                r_game_over;

    state_t              w_state_nxt;
    logic [7:0]          w_window_nxt;
    logic [HC_W-1:0]     w_hitcnt_nxt;
    logic [IDX_W-1:0]    w_prev_nxt;
    logic [N_MOLES-1:0]  w_moles_nxt;
    logic [SCORE_W-1:0]  w_score_nxt;
    logic [2:0]          w_lives_nxt;
    logic [3:0]          w_level_nxt;
    logic                w_hit_nxt;
    logic                w_miss_nxt;

    logic [15:0]         w_lfsr;
    logic                w_tick;
    logic [N_MOLES-1:0]  w_edges;
    logic                w_right;
    logic                w_wrong;
    logic                w_expire;
    logic                w_hit;
    logic                w_miss;
    logic [IDX_W-1:0]    w_raw_idx;
    logic [IDX_W-1:0]    w_idx;
    logic [N_MOLES-1:0]  w_onehot;
    logic [7:0]          w_win_load;
    int                  w_diff;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (w_lfsr)
    );

    assign w_tick   = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_edges  = bus.switch & ~r_switch_q;
    assign w_right  = |(w_edges & r_moles);
    assign w_wrong  = |(w_edges & ~r_moles);
    assign w_expire = w_tick && (r_window <= 8'd1);
    // A wrong edge poisons a simultaneous correct one; a correct edge beats expiry
    assign w_miss   = w_wrong || (w_expire && !w_right);
    assign w_hit    = w_right && !w_wrong;

    assign w_raw_idx = IDX_W'(w_lfsr % 16'(N_MOLES));

    always_comb begin
        w_idx = w_raw_idx;
        if (w_raw_idx == r_prev) begin
            w_idx = (w_raw_idx == IDX_W'(N_MOLES - 1)) ? '0 : w_raw_idx + IDX_W'(1);
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_idx] = 1'b1;
    end

    always_comb begin
        w_diff     = BASE_WINDOW - int'(r_level);
        w_win_load = (w_diff > MIN_WINDOW) ? 8'(w_diff) : 8'(MIN_WINDOW);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_window_nxt = r_window;
        w_hitcnt_nxt = r_hitcnt;
        w_prev_nxt   = r_prev;
        w_moles_nxt  = r_moles;
        w_score_nxt  = r_score;
        w_lives_nxt  = r_lives;
        w_level_nxt  = r_level;
        w_hit_nxt    = 1'b0;
        w_miss_nxt   = 1'b0;

        case (r_state)
            IDLE, OVER: begin
                if (bus.start) begin
                    w_score_nxt  = '0;
                    w_lives_nxt  = 3'(LIVES);
                    w_level_nxt  = '0;
                    w_hitcnt_nxt = '0;
                    w_state_nxt  = SPAWN;
                end
            end
            SPAWN: begin
                w_moles_nxt  = w_onehot;
                w_prev_nxt   = w_idx;
                w_window_nxt = w_win_load;
                w_state_nxt  = ACTIVE;
            end
            ACTIVE: begin
                if (w_miss) begin
                    w_lives_nxt = r_lives - 3'd1;
                    w_miss_nxt  = 1'b1;
                    w_moles_nxt = '0;
                    w_state_nxt = (r_lives == 3'd1) ? OVER : GAP;
                end else if (w_hit) begin
                    if (r_score != SCORE_MAX) begin
                        w_score_nxt = r_score + SCORE_W'(1);
                    end
                    if (r_hitcnt == HC_W'(LEVEL_STEP - 1)) begin
                        w_hitcnt_nxt = '0;
                        if (r_level != MAX_LEVEL) begin
                            w_level_nxt = r_level + 4'd1;
                        end
                    end else begin
                        w_hitcnt_nxt = r_hitcnt + HC_W'(1);
                    end
                    w_hit_nxt   = 1'b1;
                    w_moles_nxt = '0;
                    w_state_nxt = GAP;
                end else if (w_tick) begin
                    w_window_nxt = r_window - 8'd1;
                end
            end
            GAP: begin
                if (w_tick) begin
                    w_state_nxt = SPAWN;
                end
            end
            default: begin
                w_moles_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_div        <= '0;
            r_window     <= '0;
            r_hitcnt     <= '0;
            r_prev       <= '0;
            r_switch_q   <= '0;
            r_moles      <= '0;
            r_score      <= '0;
            r_lives      <= 3'(LIVES);
            r_level      <= '0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_div        <= w_tick ? '0 : r_div + DIV_W'(1);
            r_window     <= w_window_nxt;
            r_hitcnt     <= w_hitcnt_nxt;
            r_prev       <= w_prev_nxt;
            r_switch_q   <= bus.switch;
            r_moles      <= w_moles_nxt;
            r_score      <= w_score_nxt;
            r_lives      <= w_lives_nxt;
            r_level      <= w_level_nxt;
            r_hit_pulse  <= w_hit_nxt;
            r_miss_pulse <= w_miss_nxt;
            r_game_over  <= (w_state_nxt == OVER);
        end
    end

    assign bus.moles      = r_moles;
    assign bus.score      = r_score;
    assign bus.lives      = r_lives;
    assign bus.level      = r_level;
    assign bus.hit_pulse  = r_hit_pulse;
    assign bus.miss_pulse = r_miss_pulse;
    assign bus.game_over  = r_game_over;

endmodule

// File: doc/whackmole_game.md
WHACKMOLE_GAME -- requirements
Module: whackmole_game

Interface
REQ-001 The block SHALL have parameter N_MOLES, default 18, meaning the number of mole positions (2..32).
REQ-002 The block SHALL have parameter TICK_DIV, default 50_000_000, meaning clk cycles per game tick.
REQ-003 The block SHALL have parameter SCORE_W, default 11, meaning the score width.
REQ-004 The block SHALL have parameter LIVES, default 3, meaning the misses allowed per game (1..7).
REQ-005 The block SHALL have parameter LEVEL_STEP, default 8, meaning the hits needed to advance one level.
REQ-006 The block SHALL have parameter MIN_WINDOW, default 2, meaning the shortest mole-visible window, in ticks.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-009 The block SHALL have port start, input, 1 bit: single-cycle start request.
REQ-010 The block SHALL have port switch, input, N_MOLES bits: player switches, already synchronised.
REQ-011 The block SHALL have port moles, output, N_MOLES bits: the lit mole position (one-hot or zero).
REQ-012 The block SHALL have port score, output, SCORE_W bits: the hit count.
REQ-013 The block SHALL have port lives, output, 3 bits: the lives remaining.
REQ-014 The block SHALL have port level, output, 4 bits: the current level (0..15).
REQ-015 The block SHALL have port hit_pulse, output, 1 bit: a one-cycle pulse per hit.
REQ-016 The block SHALL have port miss_pulse, output, 1 bit: a one-cycle pulse per miss.
REQ-017 The block SHALL have port game_over, output, 1 bit: high while in state OVER.

Function
REQ-018 The tick divider SHALL pulse tick for one cycle every TICK_DIV clk cycles; the divider runs free in all states.
REQ-019 The FSM SHALL use the states IDLE, SPAWN, ACTIVE, GAP and OVER.
REQ-020 IDLE/OVER: a start pulse SHALL do four things on the next edge: clear score, load lives=LIVES, clear level and the hit counter, and go to SPAWN; otherwise the state SHALL hold.
REQ-021 SPAWN (1 cycle):
- idx SHALL be lfsr[15:0] mod N_MOLES.
- If idx equals the previous mole, the block SHALL use (idx+1) mod N_MOLES instead.
- The block SHALL set moles to one-hot idx, load window = max(MIN_WINDOW, 8 - level), and go to ACTIVE.
REQ-022 ACTIVE, decrementing: window SHALL decrement on each tick.
REQ-023 ACTIVE, hit: a switch rising edge (switch & ~switch_q) on the lit bit only SHALL count as a hit.
REQ-024 ACTIVE, miss: a rising edge on any unlit bit SHALL count as a miss, and window reaching 0 on a tick SHALL count as a miss.
REQ-025 Simultaneous events:
- Correct and wrong edges in the same cycle SHALL count as a miss.
- A hit and the expiring tick in the same cycle SHALL count as a hit.
REQ-026 On a hit, the block SHALL:
- Increment score, saturating at 2^SCORE_W-1.
- Increment the hit counter.
- When the hit counter reaches LEVEL_STEP, clear it and increment level, saturating at 15.
- Pulse hit_pulse and go to GAP.
REQ-027 On a miss, the block SHALL decrement lives and pulse miss_pulse; if lives becomes 0 it SHALL go to OVER, otherwise to GAP.
REQ-028 GAP: moles SHALL be 0, switches SHALL be ignored, and the block SHALL go to SPAWN on the next tick.
REQ-029 moles SHALL be 0 in IDLE, GAP and OVER.
REQ-030 hit_pulse and miss_pulse SHALL never be high in the same cycle.
REQ-031 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, and SHALL advance every clk cycle in all states.
REQ-032 A start pulse outside IDLE/OVER SHALL be ignored.

Reset
REQ-033 With reset low at a clk edge, the block SHALL:
- Enter IDLE.
- Set moles=0, score=0, lives=LIVES, level=0, hit_pulse=0, miss_pulse=0, game_over=0.
- Clear the divider, window and hit counter.
- Seed the LFSR to 16'hACE1, clear switch_q and clear the previous mole.
REQ-034 Reset mid-game SHALL abandon the round with no hit_pulse or miss_pulse generated.

Structure
REQ-035 Package whackmole_pkg SHALL hold the state enum, LFSR_SEED (16'hACE1), LFSR_TAPS, and MAX_LEVEL (15).
REQ-036 The LFSR SHALL be sub-module lfsr16 (ports clk, reset, value[15:0]); all other logic SHALL stay in whackmole_game.
REQ-037 All outputs SHALL be registered.

Verification
Scenarios REQ-038 to REQ-042 use TICK_DIV=4, N_MOLES=18, LIVES=3, LEVEL_STEP=8, MIN_WINDOW=2.
REQ-038 Reset low for 2 cycles, then release -> the block SHALL show IDLE, moles=0, score=0, lives=3, level=0, and the first SPAWN after start SHALL light bit (16'hACE1 advanced by the elapsed cycles) mod 18.
REQ-039 Start, then a rising edge on the lit bit during ACTIVE -> the block SHALL assert hit_pulse for 1 cycle and show score=1, lives=3, moles=0 next cycle.
REQ-040 Start with no switch activity -> the block SHALL give a miss at window expiry (8 ticks = 32 cycles after SPAWN) and show lives=2; after three such windows it SHALL show lives=0, game_over=1, moles=0.
REQ-041 Eight consecutive hits -> the block SHALL show level=1 and load window=7 on the next SPAWN; with level forced to 15 via hits it SHALL load window=2.
REQ-042 Lit-bit and wrong-bit edges in the same cycle -> the block SHALL give miss_pulse=1, hit_pulse=0, and score unchanged; a lit-bit edge coinciding with the expiring tick SHALL give hit_pulse=1.
REQ-043 With SCORE_W=3 and 9 hits -> the block SHALL show score saturated at 7; reset asserted during ACTIVE SHALL give IDLE next cycle with no pulse, and a start while in ACTIVE SHALL be ignored.
